// File: rtl/multicycle_control.sv
// Multicycle control sequencer for the RV-subset datapath (add, sub, or, and, lw, sw, beq).
// It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and waits on the memory ready handshake.
// Optional feature: define CTRL_INSTRET_EN to build the retired-instruction counter.
module multicycle_control #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [WIDTH-1:0] instruction_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             oldpc_write_o,
  output logic             ir_write_o,
  output logic             iord_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic             regwrite_o,
  output logic             memtoreg_o,
  output logic             pcsrc_o,
  output logic [1:0]       alusrca_o,
  output logic [1:0]       alusrcb_o,
  output logic [3:0]       aluop_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic [31:0]      instret_o
);

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_HALT   = 3'b111
  } state_e;

  typedef enum logic [2:0] {
    K_ADD, K_SUB, K_OR, K_AND, K_LW, K_SW, K_BEQ, K_BAD
  } kind_e;

  state_e state_q, state_d;
  kind_e  kind_c;
  logic   retire_c;

  logic [6:0] opcode_c;
  logic [2:0] funct3_c;
  logic       f7b_c;

  assign opcode_c = instruction_i[6:0];
  assign funct3_c = instruction_i[14:12];
  assign f7b_c    = instruction_i[30];

  // Bits of the instruction that play no part in control decode.
  logic unused_instr_c;
  assign unused_instr_c = ^{instruction_i[31], instruction_i[29:15], instruction_i[11:7]};

  // Classify the instruction; anything not listed is illegal.
  always_comb begin
    kind_c = K_BAD;
    case (opcode_c)
      OP_R: begin
        if (funct3_c == 3'b000)              kind_c = f7b_c ? K_SUB : K_ADD;
        else if (funct3_c == 3'b110 && !f7b_c) kind_c = K_OR;
        else if (funct3_c == 3'b111 && !f7b_c) kind_c = K_AND;
      end
      OP_LOAD:   if (funct3_c == 3'b010) kind_c = K_LW;
      OP_STORE:  if (funct3_c == 3'b010) kind_c = K_SW;
      OP_BRANCH: if (funct3_c == 3'b000) kind_c = K_BEQ;
      default:   kind_c = K_BAD;
    endcase
  end

  // State register; reset drops any in-flight access immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and control outputs decoded from the current state and instruction.
  always_comb begin
    state_d       = state_q;
    retire_c      = 1'b0;
    pc_write_o    = 1'b0;
    oldpc_write_o = 1'b0;
    ir_write_o    = 1'b0;
    iord_o        = 1'b0;
    memread_o     = 1'b0;
    memwrite_o    = 1'b0;
    regwrite_o    = 1'b0;
    memtoreg_o    = 1'b0;
    pcsrc_o       = 1'b0;
    alusrca_o     = 2'b00;
    alusrcb_o     = 2'b00;
    aluop_o       = 4'b1111;
    illegal_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        aluop_o = 4'b0000;
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        memread_o = 1'b1;
        alusrcb_o = 2'b01;
        aluop_o   = 4'b0010;
        if (mem_ready_i) begin
          ir_write_o    = 1'b1;
          oldpc_write_o = 1'b1;
          pc_write_o    = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
        aluop_o   = 4'b0010;
        state_d   = (kind_c == K_BAD) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alusrca_o = 2'b10;
        case (kind_c)
          K_ADD: begin aluop_o = 4'b0010; state_d = S_WB; end
          K_SUB: begin aluop_o = 4'b0110; state_d = S_WB; end
          K_OR:  begin aluop_o = 4'b0001; state_d = S_WB; end
          K_AND: begin aluop_o = 4'b0000; state_d = S_WB; end
          K_LW, K_SW: begin
            alusrcb_o = 2'b10;
            aluop_o   = 4'b0010;
            state_d   = S_MEM;
          end
          K_BEQ: begin
            aluop_o    = 4'b0110;
            pcsrc_o    = 1'b1;
            pc_write_o = zero_i;
            state_d    = S_FETCH;
            retire_c   = 1'b1;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        iord_o     = 1'b1;
        memread_o  = (kind_c == K_LW);
        memwrite_o = (kind_c == K_SW);
        if (mem_ready_i) begin
          if (kind_c == K_LW) begin
            state_d = S_WB;
          end else begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
        end
      end
      S_WB: begin
        regwrite_o = 1'b1;
        memtoreg_o = (kind_c == K_LW);
        state_d    = S_FETCH;
        retire_c   = 1'b1;
      end
      S_HALT: begin
        aluop_o   = 4'b0000;
        illegal_o = 1'b1;
      end
      default: begin
        aluop_o = 4'b0000;
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_o = state_q;

`ifdef CTRL_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  // Count retire transitions back into FETCH; wraps naturally.
  always_comb begin
    instret_d = instret_q;
    if (retire_c) instret_d = instret_q + CNT_W'(1);
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) instret_q <= '0;
    else         instret_q <= instret_d;
  end

  assign instret_o = instret_q;
`else
  logic unused_retire_c;
  assign unused_retire_c = retire_c;
  assign instret_o       = CNT_W'(0);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic        clk_i, rst_ni, run_i, zero_i, mem_ready_i;
  logic [31:0] instruction_i;
  logic        pc_write_o, oldpc_write_o, ir_write_o, iord_o, memread_o, memwrite_o;
  logic        regwrite_o, memtoreg_o, pcsrc_o, illegal_o;
  logic [1:0]  alusrca_o, alusrcb_o;
  logic [3:0]  aluop_o;
  logic [2:0]  state_o;
  logic [31:0] instret_o;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .instruction_i(instruction_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .oldpc_write_o(oldpc_write_o), .ir_write_o(ir_write_o),
    .iord_o(iord_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o), .pcsrc_o(pcsrc_o),
    .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o), .aluop_o(aluop_o),
    .state_o(state_o), .illegal_o(illegal_o), .instret_o(instret_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // {pcw, oldpcw, irw, iord, memread, memwrite, regwrite, memtoreg, pcsrc, srca, srcb, aluop}
  logic [16:0] ctrl;
  assign ctrl = {pc_write_o, oldpc_write_o, ir_write_o, iord_o, memread_o, memwrite_o,
                 regwrite_o, memtoreg_o, pcsrc_o, alusrca_o, alusrcb_o, aluop_o};

  localparam logic [16:0] C_ZERO      = 17'd0;
  localparam logic [16:0] C_FETCH_RDY = {3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0010};
  localparam logic [16:0] C_FETCH_WT  = {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0010};
  localparam logic [16:0] C_DECODE    = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 4'b0010};
  localparam logic [16:0] C_EX_ADD    = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0010};
  localparam logic [16:0] C_EX_SUB    = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0110};
  localparam logic [16:0] C_EX_OR     = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0001};
  localparam logic [16:0] C_EX_AND    = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0000};
  localparam logic [16:0] C_EX_MEM    = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 4'b0010};
  localparam logic [16:0] C_EX_BEQ_T  = {3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 4'b0110};
  localparam logic [16:0] C_EX_BEQ_N  = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 4'b0110};
  localparam logic [16:0] C_MEM_LW    = {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1111};
  localparam logic [16:0] C_MEM_SW    = {3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1111};
  localparam logic [16:0] C_WB_R      = {3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1111};
  localparam logic [16:0] C_WB_LW     = {3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 4'b1111};

  localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010, S_EXEC = 3'b011,
                         S_MEM = 3'b100, S_WB = 3'b101, S_HALT = 3'b111;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive handshake inputs, check state/controls mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [16:0] ctl,
                     input logic rdy, input logic z);
    mem_ready_i = rdy;
    zero_i      = z;
    #1;
    check($sformatf("%s_state", tag), 32'(state_o), 32'(st));
    check($sformatf("%s_ctrl", tag), 32'(ctrl), 32'(ctl));
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_instret(input string tag, input int unsigned n);
`ifdef CTRL_INSTRET_EN
    check(tag, instret_o, 32'(n));
`else
    check(tag, instret_o, 32'd0);
`endif
  endtask

  task automatic run_rtype(input string tag, input logic [31:0] ins, input logic [16:0] ex_ctl);
    instruction_i = ins;
    cyc({tag, "_f"}, S_FETCH, C_FETCH_RDY, 1'b1, 1'b0);
    cyc({tag, "_d"}, S_DECODE, C_DECODE, 1'b0, 1'b0);
    cyc({tag, "_e"}, S_EXEC, ex_ctl, 1'b1, 1'b0);
    cyc({tag, "_w"}, S_WB, C_WB_R, 1'b0, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; run_i = 1'b0; zero_i = 1'b0; mem_ready_i = 1'b0; instruction_i = 32'd0;
    #3;
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    check("rst_ctrl", 32'(ctrl), 32'(C_ZERO));
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_instret", instret_o, 32'd0);
    #4 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    cyc("idle_norun", S_IDLE, C_ZERO, 1'b1, 1'b0);
    run_i = 1'b1;
    cyc("idle_run", S_IDLE, C_ZERO, 1'b0, 1'b0);
    run_i = 1'b0;

    run_rtype("add", 32'h002081B3, C_EX_ADD);
    check_instret("instret_add", 1);
    run_rtype("sub", 32'h402081B3, C_EX_SUB);
    run_rtype("or", 32'h0020E1B3, C_EX_OR);
    check("illegal_after_or", 32'(illegal_o), 32'd0);
    run_rtype("and", 32'h0020F1B3, C_EX_AND);
    check_instret("instret_r", 4);

    // lw with two memory wait cycles: 7 cycles FETCH to FETCH.
    instruction_i = 32'h0000A183;
    cyc("lw_f", S_FETCH, C_FETCH_RDY, 1'b1, 1'b0);
    cyc("lw_d", S_DECODE, C_DECODE, 1'b1, 1'b0);
    cyc("lw_e", S_EXEC, C_EX_MEM, 1'b0, 1'b0);
    cyc("lw_m0", S_MEM, C_MEM_LW, 1'b0, 1'b0);
    cyc("lw_m1", S_MEM, C_MEM_LW, 1'b0, 1'b0);
    cyc("lw_m2", S_MEM, C_MEM_LW, 1'b1, 1'b0);
    cyc("lw_w", S_WB, C_WB_LW, 1'b0, 1'b0);
    check("lw_back_fetch", 32'(state_o), 32'(S_FETCH));
    check_instret("instret_lw", 5);

    // sw with one fetch wait cycle.
    instruction_i = 32'h0030A223;
    cyc("sw_fw", S_FETCH, C_FETCH_WT, 1'b0, 1'b0);
    cyc("sw_f", S_FETCH, C_FETCH_RDY, 1'b1, 1'b0);
    cyc("sw_d", S_DECODE, C_DECODE, 1'b0, 1'b0);
    cyc("sw_e", S_EXEC, C_EX_MEM, 1'b0, 1'b0);
    cyc("sw_m", S_MEM, C_MEM_SW, 1'b1, 1'b0);
    check_instret("instret_sw", 6);

    // beq taken and not taken.
    instruction_i = 32'h00208463;
    cyc("beqt_f", S_FETCH, C_FETCH_RDY, 1'b1, 1'b0);
    cyc("beqt_d", S_DECODE, C_DECODE, 1'b0, 1'b1);
    cyc("beqt_e", S_EXEC, C_EX_BEQ_T, 1'b0, 1'b1);
    cyc("beqn_f", S_FETCH, C_FETCH_RDY, 1'b1, 1'b0);
    cyc("beqn_d", S_DECODE, C_DECODE, 1'b0, 1'b0);
    cyc("beqn_e", S_EXEC, C_EX_BEQ_N, 1'b1, 1'b0);
    check("beq_back_fetch", 32'(state_o), 32'(S_FETCH));
    check_instret("instret_beq", 8);

    // Illegal opcode halts; RUN toggles ignored.
    instruction_i = 32'h0000007F;
    cyc("ill_f", S_FETCH, C_FETCH_RDY, 1'b1, 1'b0);
    cyc("ill_d", S_DECODE, C_DECODE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_i = i[0];
      check("halt_illegal", 32'(illegal_o), 32'd1);
      cyc("halt", S_HALT, C_ZERO, 1'b1, 1'b0);
    end
    run_i = 1'b0;
    check_instret("instret_halt", 8);

    // Asynchronous reset out of HALT.
    rst_ni = 1'b0;
    #1;
    check("halt_rst_state", 32'(state_o), 32'(S_IDLE));
    check("halt_rst_illegal", 32'(illegal_o), 32'd0);
    check("halt_rst_instret", instret_o, 32'd0);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset during an sw memory access drops the write immediately.
    run_i = 1'b1;
    instruction_i = 32'h0030A223;
    cyc("sw2_idle", S_IDLE, C_ZERO, 1'b0, 1'b0);
    run_i = 1'b0;
    cyc("sw2_f", S_FETCH, C_FETCH_RDY, 1'b1, 1'b0);
    cyc("sw2_d", S_DECODE, C_DECODE, 1'b0, 1'b0);
    cyc("sw2_e", S_EXEC, C_EX_MEM, 1'b0, 1'b0);
    mem_ready_i = 1'b0;
    #1;
    check("sw2_m_ctrl", 32'(ctrl), 32'(C_MEM_SW));
    rst_ni = 1'b0;
    #1;
    check("sw2_rst_memwrite", 32'(memwrite_o), 32'd0);
    check("sw2_rst_state", 32'(state_o), 32'(S_IDLE));
    check("sw2_rst_instret", instret_o, 32'd0);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("sw2_post_idle", 32'(state_o), 32'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
